// File: rtl/ro_seq_pkg.sv
// Shared definitions for the RO sample sequencer: FSM encoding and sampling constants.
package ro_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        SAMPLE = 2'd2
    } seq_state_t;

    localparam int LANE_BITS     = 3;
    localparam int SAMPLE_PERIOD = 8;
    localparam int RCT_LIMIT     = 4;
    localparam int BYTE_W        = 8;

endpackage

// File: rtl/ro_byte_fifo.sv
// First-word fall-through byte FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module ro_byte_fifo
    import ro_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head reads as zero while empty so the output is defined straight out of reset.
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ro_sample_sequencer.sv
// Enables both ROs, waits for the XOR buffer to fill, then captures one byte lane
// every SAMPLE_PERIOD clocks into an output FIFO. RO_SEQ_RCT_EN adds a repetition-count health test.
module ro_sample_sequencer
    import ro_seq_pkg::*;
#(
    parameter int FILL_CYCLES = 66,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [LANE_BITS-1:0] lane_sel,
    input  logic [CNT_W-1:0]     req_bytes,
    input  logic [BYTE_W-1:0]    buf_data,
    output logic                 ro_activate_1,
    output logic                 ro_activate_2,
    output logic [LANE_BITS-1:0] out_sel,
    output logic [BYTE_W-1:0]    dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 busy,
    output logic                 overflow,
`ifdef RO_SEQ_RCT_EN
    output logic                 health_fail,
`endif
    output logic [1:0]           fsm_state
);

    // Output handshake: a byte transfers on every clock where dout_valid and
    // dout_ready are both high; dout holds the FIFO head whenever dout_valid is high.

    localparam int WARM_W  = $clog2(FILL_CYCLES + 1);
    localparam int PHASE_W = $clog2(SAMPLE_PERIOD);
    localparam logic [WARM_W-1:0]  WARM_LAST  = WARM_W'(FILL_CYCLES - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SAMPLE_PERIOD - 1);

    seq_state_t           state_q;
    seq_state_t           state_d;
    logic [WARM_W-1:0]    warm_cnt;
    logic [PHASE_W-1:0]   phase;
    logic [CNT_W-1:0]     remaining;
    logic                 run_forever;
    logic [LANE_BITS-1:0] out_sel_q;
    logic                 overflow_q;

    logic start_accept;
    logic capture;
    logic push;
    logic drop;
    logic rct_trip;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;

    assign start_accept = (state_q == IDLE) && start && !abort;
    assign capture      = (state_q == SAMPLE) && (phase == PHASE_LAST) && !abort;
    assign fifo_pop     = dout_valid && dout_ready;

`ifdef RO_SEQ_RCT_EN
    localparam int RCT_W = $clog2(RCT_LIMIT + 1);
    localparam logic [RCT_W-1:0] RCT_LAST = RCT_W'(RCT_LIMIT - 1);

    logic [RCT_W-1:0]  rct_cnt;
    logic [BYTE_W-1:0] rct_last;
    logic              health_q;

    // The run counter restarts at zero on each start, so the first capture never matches.
    assign rct_trip    = capture && (rct_cnt == RCT_LAST) && (buf_data == rct_last);
    assign health_fail = health_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rct_cnt  <= '0;
            rct_last <= '0;
            health_q <= 1'b0;
        end else begin
            if (start_accept) begin
                rct_cnt  <= '0;
                health_q <= 1'b0;
            end else if (capture) begin
                rct_last <= buf_data;
                if ((rct_cnt != '0) && (buf_data == rct_last)) begin
                    rct_cnt <= rct_cnt + RCT_W'(1);
                end else begin
                    rct_cnt <= RCT_W'(1);
                end
                if (rct_trip) begin
                    health_q <= 1'b1;
                end
            end
        end
    end
`else
    assign rct_trip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            IDLE:    if (start) state_d = WARMUP;
            WARMUP:  if (warm_cnt == WARM_LAST) state_d = SAMPLE;
            SAMPLE:  state_d = SAMPLE;
            default: state_d = IDLE;
        endcase
        if (capture) begin
            if (rct_trip) begin
                state_d = IDLE;
            end else if (!fifo_full || fifo_pop) begin
                push = 1'b1;
                if (!run_forever && (remaining == CNT_W'(1))) begin
                    state_d = IDLE;
                end
            end else begin
                drop = 1'b1;
            end
        end
        if (abort) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            warm_cnt    <= '0;
            phase       <= '0;
            remaining   <= '0;
            run_forever <= 1'b0;
            out_sel_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_accept) begin
                out_sel_q   <= lane_sel;
                remaining   <= req_bytes;
                run_forever <= (req_bytes == '0);
                overflow_q  <= 1'b0;
                warm_cnt    <= '0;
            end
            if (state_q == WARMUP) begin
                warm_cnt <= warm_cnt + WARM_W'(1);
                phase    <= '0;
            end
            if (state_q == SAMPLE) begin
                phase <= phase + PHASE_W'(1);
            end
            if (push && !run_forever) begin
                remaining <= remaining - CNT_W'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    ro_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(buf_data),
        .pop      (fifo_pop),
        .head     (dout),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign dout_valid    = !fifo_empty;
    assign busy          = (state_q != IDLE);
    assign ro_activate_1 = busy;
    assign ro_activate_2 = busy;
    assign out_sel       = out_sel_q;
    assign overflow      = overflow_q;
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_ro_sample_sequencer.sv
// Directed bench for ro_sample_sequencer with a byte scoreboard; exercises the
// health test as well when RO_SEQ_RCT_EN is defined.
module tb_ro_sample_sequencer;

    localparam int FILL   = 66;
    localparam int DEPTH  = 4;
    localparam int PERIOD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [2:0] lane_sel;
    logic [7:0] req_bytes;
    logic [7:0] buf_data;
    logic       ro_activate_1;
    logic       ro_activate_2;
    logic [2:0] out_sel;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       busy;
    logic       overflow;
    logic [1:0] fsm_state;
`ifdef RO_SEQ_RCT_EN
    logic       health_fail;
`endif

    ro_sample_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .lane_sel     (lane_sel),
        .req_bytes    (req_bytes),
        .buf_data     (buf_data),
        .ro_activate_1(ro_activate_1),
        .ro_activate_2(ro_activate_2),
        .out_sel      (out_sel),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .busy         (busy),
        .overflow     (overflow),
`ifdef RO_SEQ_RCT_EN
        .health_fail  (health_fail),
`endif
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    // Scoreboard and reference model state.
    logic [7:0] exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         pops = 0;
    bit         run_active = 0;
    bit         run_forever = 0;
    int         cap_edge = 0;
    int         cap_left = 0;
    int         start_cyc = 0;
    bit         exp_ovf = 0;
    logic [2:0] exp_lane = '0;
    bit         const_aa = 0;
`ifdef RO_SEQ_RCT_EN
    bit         exp_health = 0;
    int         rct_n = 0;
    logic [7:0] rct_last = '0;
`endif

    function automatic logic [7:0] pat(int c);
        int k;
        k = (c % 15) + 1;
        return 8'(k * 17);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: advance the model on the edge, then check outputs and drive new data.
    task automatic tick();
        logic       st, ab, pop_now, was_active, tripped;
        logic [7:0] bd;
        logic [7:0] rq;
        logic [2:0] ln;
        int         exp_state;
        st = start; ab = abort; bd = buf_data; rq = req_bytes; ln = lane_sel;
        was_active = run_active;
        pop_now = dout_ready && (exp_q.size() != 0) && !rst_n;
        @(posedge clk);
        cyc++;
        if (pop_now) begin
            void'(exp_q.pop_front());
            pops++;
        end
        if (was_active && ab) begin
            run_active = 0;
        end else if (was_active && cyc == cap_edge) begin
            cap_edge += PERIOD;
            tripped = 0;
`ifdef RO_SEQ_RCT_EN
            if (rct_n != 0 && bd == rct_last) rct_n++;
            else rct_n = 1;
            rct_last = bd;
            if (rct_n == 4) begin
                tripped = 1;
                exp_health = 1;
                run_active = 0;
            end
`endif
            if (!tripped) begin
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back(bd);
                    if (!run_forever) begin
                        cap_left--;
                        if (cap_left == 0) run_active = 0;
                    end
                end else begin
                    exp_ovf = 1;
                end
            end
        end else if (!was_active && st && !ab && !rst_n) begin
            run_active  = 1;
            run_forever = (rq == 0);
            cap_left    = rq;
            cap_edge    = cyc + FILL + PERIOD;
            start_cyc   = cyc;
            exp_lane    = ln;
            exp_ovf     = 0;
`ifdef RO_SEQ_RCT_EN
            exp_health  = 0;
            rct_n       = 0;
`endif
        end
        #1;
        exp_state = !run_active ? 0 : ((cyc - start_cyc < FILL) ? 1 : 2);
        check("busy", busy, run_active);
        check("ro_activate_1", ro_activate_1, run_active);
        check("ro_activate_2", ro_activate_2, run_active);
        check("fsm_state", fsm_state, exp_state);
        check("out_sel", out_sel, exp_lane);
        check("overflow", overflow, exp_ovf);
        check("dout_valid", dout_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("dout", dout, exp_q[0]);
`ifdef RO_SEQ_RCT_EN
        check("health_fail", health_fail, exp_health);
`endif
        buf_data = const_aa ? 8'hAA : pat(cyc);
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        run_active = 0;
        exp_q.delete();
        exp_ovf = 0;
        exp_lane = '0;
`ifdef RO_SEQ_RCT_EN
        exp_health = 0;
`endif
        #1;
        check("rst_dout_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_sel", out_sel, 0);
        check("rst_dout", dout, 0);
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
    endtask

    task automatic pulse_start(input logic [2:0] ln, input logic [7:0] rq);
        start = 1'b1;
        lane_sel = ln;
        req_bytes = rq;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((run_active || exp_q.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        check("idle_timeout", n < bound, 1);
    endtask

    task automatic tick_until(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        int s;
        int p0;
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        lane_sel = '0;
        req_bytes = '0;
        buf_data = '0;
        dout_ready = 1'b0;

        // Reset, then a two-byte run on lane 3.
        do_reset();
        dout_ready = 1'b1;
        p0 = pops;
        pulse_start(3'd3, 8'd2);
        s = cyc;
        check("out_sel_after_start", out_sel, 3);
        check("ro_on_after_start", ro_activate_1, 1);
        for (int n = 0; n < 200 && !dout_valid; n++) tick();
        // First byte visible FILL+8 edges after the edge that sampled start
        // (75 when the start-sampling edge counts as the first).
        check("first_valid_edge", cyc - s, FILL + PERIOD);
        wait_idle(400);
        repeat (4) tick();
        check("run1_bytes", pops - p0, 2);

        // Six bytes with the consumer stalled: four queue, the fifth is dropped.
        dout_ready = 1'b0;
        p0 = pops;
        pulse_start(3'd2, 8'd6);
        s = cyc;
        tick_until(s + 110);
        check("stall_overflow", overflow, 1);
        check("stall_busy", busy, 1);
        dout_ready = 1'b1;
        wait_idle(400);
        repeat (4) tick();
        check("run2_bytes", pops - p0, 6);
        check("run2_overflow_sticky", overflow, 1);

        // Full FIFO with a pop and a capture on the same edge, then abort on a capture edge.
        dout_ready = 1'b0;
        p0 = pops;
        pulse_start(3'd4, 8'd0);
        s = cyc;
        tick_until(s + 105);
        check("full_before_pop", dout_valid, 1);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check("full_pop_push_no_ovf", overflow, 0);
        tick_until(s + 109);
        dout_ready = 1'b1;
        repeat (2) tick();
        dout_ready = 1'b0;
        tick_until(s + 113);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_no_ovf", overflow, 0);
        dout_ready = 1'b1;
        wait_idle(100);
        check("run3_bytes", pops - p0, 5);

        // Start while busy is ignored.
        p0 = pops;
        pulse_start(3'd1, 8'd2);
        repeat (20) tick();
        pulse_start(3'd5, 8'd7);
        check("busy_start_out_sel", out_sel, 1);
        wait_idle(400);
        repeat (10) tick();
        check("run4_bytes", pops - p0, 2);

        // Reset in the middle of a run discards everything.
        dout_ready = 1'b0;
        pulse_start(3'd6, 8'd3);
        repeat (80) tick();
        check("pre_reset_valid", dout_valid, 1);
        do_reset();
        check("post_reset_valid", dout_valid, 0);

`ifdef RO_SEQ_RCT_EN
        // Constant source: three captures pushed, the fourth trips the health test.
        const_aa = 1;
        buf_data = 8'hAA;
        p0 = pops;
        pulse_start(3'd0, 8'd0);
        s = cyc;
        tick_until(s + 100);
        check("rct_health", health_fail, 1);
        check("rct_idle", busy, 0);
        const_aa = 0;
        pulse_start(3'd0, 8'd0);
        check("rct_cleared", health_fail, 0);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        dout_ready = 1'b1;
        wait_idle(100);
        check("rct_bytes", pops - p0, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ro_sample_sequencer.md
Name: ro_sample_sequencer

Overview:
- Controller and byte collector directly downstream of the dual-RO XOR buffer.
- Enables both ring oscillators and waits for the buffer's 64-bit shift register to fill.
- Holds a fixed byte lane on out_sel and captures that lane every 8 clocks, giving a contiguous stream of non-overlapping bytes.
- Queues captured bytes in a small FIFO with a valid/ready output for the chip-level readout.

Parameters:
- FILL_CYCLES, 66, warm-up clocks after RO enable (1 RO sync reg + 64 shift + 1 out reg).
- FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 2.
- CNT_W, 8, width of the requested-byte counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; latches lane_sel and req_bytes; ignored unless IDLE.
- abort  in  1  returns FSM to IDLE next cycle; FIFO contents kept.
- lane_sel  in  3  byte lane to sample (0 = [7:0] ... 7 = [63:56]).
- req_bytes  in  CNT_W  bytes to collect; 0 = collect until abort.
- buf_data  in  8  registered byte from the buffer.
- ro_activate_1  out  1  RO1 enable.
- ro_activate_2  out  1  RO2 enable.
- out_sel  out  3  lane select to the buffer, registered.
- dout  out  8  FIFO head.
- dout_valid  out  1  FIFO not empty.
- dout_ready  in  1  consumer accepts dout when high together with dout_valid.
- busy  out  1  FSM not IDLE.
- overflow  out  1  sticky: a capture was dropped because the FIFO was full.

Behaviour:
- Reset values: all outputs 0 (ro_activate_*=0, out_sel=0, dout=0, dout_valid=0, busy=0, overflow=0). FIFO is emptied, counters cleared, FSM in IDLE.
- FSM states: IDLE, WARMUP, SAMPLE.
- IDLE, start=1: latch lane_sel into out_sel and req_bytes into the remaining counter. Clear overflow. Go to WARMUP with ro_activate_1/2 high from the next cycle.
- WARMUP: count FILL_CYCLES clocks. On the last count go to SAMPLE with phase=0.
- SAMPLE:
  - 3-bit phase counter increments every clock.
  - At phase==7, buf_data is captured. If FIFO not full: push, decrement remaining (if req_bytes was nonzero). If full: drop the byte, set overflow, leave remaining unchanged.
  - When remaining reaches 0 on a push, go to IDLE next cycle.
- ro_activate_1/2 are high in WARMUP and SAMPLE only. out_sel is constant from start until the next start.
- abort wins over every transition in the same cycle. The FSM goes to IDLE; a capture coinciding with abort is not pushed.
- start while busy is ignored.
- FIFO:
  - First-word fall-through; dout/dout_valid reflect the head in the cycle after a push into an empty FIFO.
  - A pop happens when dout_valid && dout_ready.
  - Simultaneous push and pop when full: the pop is honoured and the push is accepted (no overflow).
  - Pointers wrap modulo FIFO_DEPTH.
- First capture: FILL_CYCLES+8 clocks after the start edge. Steady throughput: 1 byte / 8 clocks.
- Reset mid-operation: immediate return to the reset state, FIFO contents lost.

Optional Feature:
- Macro: RO_SEQ_RCT_EN, a repetition-count health test.
- Defined:
  - Track consecutive identical captured bytes (pushed or dropped).
  - When 4 consecutive captures are equal, set sticky output health_fail (extra 1-bit port, reset 0, cleared on start).
  - The failing byte is not pushed and the FSM goes to IDLE.
- Undefined: no health_fail port, no comparison logic; all captures are handled as above.

Decomposition:
- Shared include/package ro_seq_pkg holds:
  - FSM state encodings (IDLE=2'd0, WARMUP=2'd1, SAMPLE=2'd2);
  - LANE_BITS=3, SAMPLE_PERIOD=8, RCT_LIMIT=4.
- One sub-module: ro_byte_fifo (parameterised depth, 8-bit FWFT, push/pop/full/empty).
- The FSM, counters and capture logic stay in ro_sample_sequencer.

Test Plan:
- Reset held, then released; start with lane_sel=3, req_bytes=2, buf_data stepping 0x11,0x22,... each clock, dout_ready=1.
  - out_sel=3 and ro_activate high one cycle after start.
  - First dout_valid at start+75 (66+8+1).
  - Exactly 2 bytes out, then busy=0.
- req_bytes=6, FIFO_DEPTH=4, dout_ready=0: 4 bytes queued, 5th capture dropped with overflow=1, busy stays 1. Raise dout_ready: all 6 bytes delivered in order, overflow stays 1.
- req_bytes=0, abort asserted on a phase==7 cycle: that byte is not pushed, busy=0 next cycle, earlier FIFO bytes still drain.
- start pulsed while busy with lane_sel=5: out_sel unchanged, run completes with the original count.
- FIFO full with pop and capture in the same cycle: no overflow, count stays 4.
- RO_SEQ_RCT_EN: buf_data constant 0xAA: 3 bytes pushed, 4th raises health_fail, FSM returns to IDLE; the next start clears health_fail.
